// File: rtl/dragonfang_pkg.sv
// Shared dragonfang types: widening-factor encodings and the writeback sequencer state.
package dragonfang_pkg;

    // Widening factor of a vector result; values 4..7 are reserved and act as "no widening".
    typedef enum logic [2:0] {
        FRACTION_NONE_MODE   = 3'd0,
        ENABLED_HALF_MODE    = 3'd1,
        ENABLED_QUARTER_MODE = 3'd2,
        ENABLED_EIGHTH_MODE  = 3'd3
    } fraction_mode_t;

    // Writeback sequencer control state.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } writeback_state_t;

    localparam int unsigned WB_WORD_WIDTH = 64;
    localparam int unsigned WB_WORD_COUNT = 8;

endpackage

// File: rtl/vector_writeback_sequencer_if.sv
// Result-in / writeback-out bundle for the vector writeback sequencer.
interface vector_writeback_sequencer_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    import dragonfang_pkg::*;

    // Producer side
    logic                      in_valid;
    logic                      in_ready;
    fraction_mode_t            fraction_mode;
    logic [REG_ADDR_WIDTH-1:0] vd_base;
    logic [63:0]               vd;
    logic [63:0]               vd_high;
    logic [383:0]              vd_extra;

    // Register-file side
    logic                      wb_valid;
    logic                      wb_ready;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [63:0]               wb_data;
    logic                      wb_last;

    // Status
    logic                      busy;
    logic                      err_misaligned;

    // Environment: drives results and writeback backpressure.
    modport master (
        output in_valid, fraction_mode, vd_base, vd, vd_high, vd_extra, wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data, wb_last, busy, err_misaligned
    );

    // Sequencer: accepts results and emits writeback beats.
    modport slave (
        input  in_valid, fraction_mode, vd_base, vd, vd_high, vd_extra, wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data, wb_last, busy, err_misaligned
    );

endinterface

// File: rtl/vector_writeback_sequencer.sv
// Splits one accepted widened vector result into 1/2/4/8 consecutive 64-bit register writebacks.
// The interface instance must be built with the same REG_ADDR_WIDTH as this module.
module vector_writeback_sequencer
    import dragonfang_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned BEAT_COUNT_MAX = 8
) (
    input logic                   clock,
    input logic                   reset,
    vector_writeback_sequencer_if.slave bus
);

    localparam int unsigned IDX_W = (BEAT_COUNT_MAX > 1) ? $clog2(BEAT_COUNT_MAX) : 1;
    localparam int unsigned CNT_W = $clog2(BEAT_COUNT_MAX + 1);

    // Beats per result; clamped so the beat index can never run past BEAT_COUNT_MAX - 1.
    function automatic logic [CNT_W-1:0] decode_beat_count(input fraction_mode_t mode);
        int unsigned n;
        case (mode)
            ENABLED_HALF_MODE:    n = 2;
            ENABLED_QUARTER_MODE: n = 4;
            ENABLED_EIGHTH_MODE:  n = 8;
            default:              n = 1;
        endcase
        if (n > BEAT_COUNT_MAX) begin
            n = BEAT_COUNT_MAX;
        end
        return CNT_W'(n);
    endfunction

    writeback_state_t                               state_q, state_d;
    logic [IDX_W-1:0]                               idx_q, idx_d;
    logic [CNT_W-1:0]                               count_q, count_d;
    logic [REG_ADDR_WIDTH-1:0]                      base_q, base_d;
    logic [WB_WORD_COUNT-1:0][WB_WORD_WIDTH-1:0]    words_q, words_d;
    logic                                           err_q, err_d;

    logic [CNT_W-1:0] in_count;
    logic             in_aligned;
    logic             last_beat;

    // Decode the incoming widening factor and check base alignment (counts are powers of two).
    always_comb begin
        in_count   = decode_beat_count(bus.fraction_mode);
        in_aligned = (bus.vd_base & REG_ADDR_WIDTH'(in_count - CNT_W'(1))) == '0;
        last_beat  = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
    end

    // Next-state and output logic; latched fields only change on an accepted handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;
        words_d = words_q;
        err_d   = 1'b0;

        bus.in_ready       = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.wb_addr        = '0;
        bus.wb_data        = '0;
        bus.wb_last        = 1'b0;
        bus.busy           = (state_q == SEND);
        bus.err_misaligned = err_q;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    words_d = {bus.vd_extra, bus.vd_high, bus.vd};
                    base_d  = bus.vd_base;
                    count_d = in_count;
                    idx_d   = '0;
                    if (in_aligned) begin
                        state_d = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                bus.wb_valid = 1'b1;
                bus.wb_addr  = base_q + REG_ADDR_WIDTH'(idx_q);
                bus.wb_data  = words_q[idx_q];
                bus.wb_last  = last_beat;
                if (bus.wb_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over any handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            base_q  <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            base_q  <= base_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

endmodule
